// File: rtl/trap_controller.sv
// Machine-mode trap/mret sequencer: arbitrates trap sources, drives the CSR write port
// through MEPC/MCAUSE/MTVAL/MSTATUS and redirects fetch. Define TRAP_VECTORED_EN for vectored IRQs.
module trap_controller #(
   parameter int unsigned DONE_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exc_illegal_i,
   input  logic        exc_ecall_i,
   input  logic        exc_ebreak_i,
   input  logic        mret_i,
   input  logic [31:0] exc_pc_i,
   input  logic [31:0] exc_tval_i,
   input  logic        irq_ext_i,
   input  logic        irq_sw_i,
   input  logic        irq_timer_i,
   input  logic [31:0] irq_pc_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mie_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   output logic        csr_we_o,
   output logic [11:0] csr_addr_o,
   output logic [31:0] csr_wdata_o,
   input  logic        csr_write_done_i,
   output logic        stall_o,
   output logic        flush_o,
   output logic        trap_taken_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o
);

   localparam logic [2:0] IDLE        = 3'd0;
   localparam logic [2:0] WR_MEPC     = 3'd1;
   localparam logic [2:0] WR_MCAUSE   = 3'd2;
   localparam logic [2:0] WR_MTVAL    = 3'd3;
   localparam logic [2:0] WR_MSTATUS  = 3'd4;
   localparam logic [2:0] MRET_STATUS = 3'd5;
   localparam logic [2:0] REDIRECT    = 3'd6;

   localparam logic [3:0] TMO_LAST = 4'(DONE_TIMEOUT - 1);

   logic [2:0]  state, state_nxt;
   logic [3:0]  cnt;
   logic [31:0] cause, epc, tval;
   logic        is_mret;

   logic        irq_en, exc_any, trap_req, advance;
   logic [31:0] cause_sel, epc_sel, tval_sel;
   logic [31:0] mstatus_trap, mstatus_mret, trap_base, trap_target;
   logic        unused_bits;

   assign irq_en  = mstatus_i[3];
   assign exc_any = exc_illegal_i | exc_ecall_i | exc_ebreak_i;

   always_comb begin
      trap_req  = 1'b1;
      cause_sel = 32'd0;
      epc_sel   = exc_pc_i;
      tval_sel  = 32'd0;
      if (exc_illegal_i) begin
         cause_sel = 32'd2;
         tval_sel  = exc_tval_i;
      end else if (exc_ecall_i) begin
         cause_sel = 32'd11;
      end else if (exc_ebreak_i) begin
         cause_sel = 32'd3;
      end else if (irq_en && irq_ext_i && mie_i[11]) begin
         cause_sel = 32'h8000_000B;
         epc_sel   = irq_pc_i;
      end else if (irq_en && irq_sw_i && mie_i[3]) begin
         cause_sel = 32'h8000_0003;
         epc_sel   = irq_pc_i;
      end else if (irq_en && irq_timer_i && mie_i[7]) begin
         cause_sel = 32'h8000_0007;
         epc_sel   = irq_pc_i;
      end else begin
         trap_req  = 1'b0;
      end
   end

   always_comb begin
      mstatus_trap        = mstatus_i;
      mstatus_trap[7]     = mstatus_i[3];
      mstatus_trap[3]     = 1'b0;
      mstatus_trap[12:11] = 2'b11;
      mstatus_mret        = mstatus_i;
      mstatus_mret[3]     = mstatus_i[7];
      mstatus_mret[7]     = 1'b1;
      mstatus_mret[12:11] = 2'b11;
   end

   assign trap_base = {mtvec_i[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
   assign trap_target = (cause[31] && mtvec_i[1:0] == 2'b01) ?
                        trap_base + {26'd0, cause[3:0], 2'b00} : trap_base;
`else
   assign trap_target = trap_base;
`endif
   assign unused_bits = ^{mie_i, mtvec_i[1:0]};

   // An acknowledge in the same cycle as the write pulse counts.
   assign advance = csr_write_done_i || (cnt == TMO_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (trap_req)    state_nxt = WR_MEPC;
            else if (mret_i) state_nxt = MRET_STATUS;
         end
         WR_MEPC:     if (advance) state_nxt = WR_MCAUSE;
         WR_MCAUSE:   if (advance) state_nxt = WR_MTVAL;
         WR_MTVAL:    if (advance) state_nxt = WR_MSTATUS;
         WR_MSTATUS:  if (advance) state_nxt = REDIRECT;
         MRET_STATUS: if (advance) state_nxt = REDIRECT;
         REDIRECT:    state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         cnt              <= 4'd0;
         cause            <= 32'd0;
         epc              <= 32'd0;
         tval             <= 32'd0;
         is_mret          <= 1'b0;
         csr_we_o         <= 1'b0;
         csr_addr_o       <= 12'd0;
         csr_wdata_o      <= 32'd0;
         flush_o          <= 1'b0;
         trap_taken_o     <= 1'b0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= 32'd0;
      end else begin
         state            <= state_nxt;
         cnt              <= cnt + 4'd1;
         csr_we_o         <= 1'b0;
         flush_o          <= 1'b0;
         trap_taken_o     <= 1'b0;
         redirect_valid_o <= 1'b0;
         if (state == IDLE) begin
            if (trap_req) begin
               cause        <= cause_sel;
               epc          <= epc_sel;
               tval         <= tval_sel;
               is_mret      <= 1'b0;
               flush_o      <= 1'b1;
               trap_taken_o <= 1'b1;
            end else if (mret_i) begin
               is_mret      <= 1'b1;
               flush_o      <= 1'b1;
            end
         end
         if (state_nxt != state) begin
            case (state_nxt)
               WR_MEPC: begin
                  csr_we_o    <= 1'b1;
                  csr_addr_o  <= 12'h341;
                  csr_wdata_o <= epc_sel;
                  cnt         <= 4'd0;
               end
               WR_MCAUSE: begin
                  csr_we_o    <= 1'b1;
                  csr_addr_o  <= 12'h342;
                  csr_wdata_o <= cause;
                  cnt         <= 4'd0;
               end
               WR_MTVAL: begin
                  csr_we_o    <= 1'b1;
                  csr_addr_o  <= 12'h343;
                  csr_wdata_o <= tval;
                  cnt         <= 4'd0;
               end
               WR_MSTATUS: begin
                  csr_we_o    <= 1'b1;
                  csr_addr_o  <= 12'h300;
                  csr_wdata_o <= mstatus_trap;
                  cnt         <= 4'd0;
               end
               MRET_STATUS: begin
                  csr_we_o    <= 1'b1;
                  csr_addr_o  <= 12'h300;
                  csr_wdata_o <= mstatus_mret;
                  cnt         <= 4'd0;
               end
               REDIRECT: begin
                  redirect_valid_o <= 1'b1;
                  redirect_pc_o    <= is_mret ? mepc_i : trap_target;
               end
               default: ;
            endcase
         end
      end
   end

   assign stall_o = (state != IDLE);

endmodule
